// File: rtl/gmii_rx_frame.sv
// gmii_rx_frame: GMII receive frame checker. Strips preamble/SFD, checks
// FCS and length, forwards payload through a 4-byte delay line.
//
// Ports:
//   Clk, mr_main_reset (async, active-low)
//   RX_DV, RXD[7:0]                : byte stream from the PCS
//   rx_data, rx_valid, rx_sof      : payload with FCS removed
//   frame_done, frame_ok, crc_err,
//   len_err, align_err, frame_len  : per-frame status, held until next strobe
//   rx_good_cnt, rx_bad_cnt        : saturating frame counters
module gmii_rx_frame #(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518
) (
    input  logic        Clk,
    input  logic        mr_main_reset,
    input  logic        RX_DV,
    input  logic [7:0]  RXD,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        rx_sof,
    output logic        frame_done,
    output logic        frame_ok,
    output logic        crc_err,
    output logic        len_err,
    output logic        align_err,
    output logic [10:0] frame_len,
    output logic [15:0] rx_good_cnt,
    output logic [15:0] rx_bad_cnt
);

    typedef enum logic [2:0] {
        WAIT_IDLE,
        IDLE,
        PREAMBLE,
        DATA,
        DROP
    } state_t;

    localparam logic [7:0]  PRE     = 8'h55;
    localparam logic [7:0]  SFD     = 8'hD5;
    localparam logic [31:0] POLY    = 32'hEDB88320;
    localparam logic [31:0] RESIDUE = 32'hDEBB20E3;
    localparam logic [10:0] MIN_L   = 11'(MIN_LEN);
    localparam logic [10:0] MAX_L   = 11'(MAX_LEN);
    localparam logic [10:0] LEN_SAT = 11'h7FF;
    localparam logic [15:0] CNT_SAT = 16'hFFFF;

    state_t state;
    state_t state_nxt;

    logic [31:0]      crc;
    logic [10:0]      len_cnt;
    // dly[0] is the newest byte, dly[3] the oldest
    logic [3:0][7:0]  dly;

    logic start_data;
    logic data_beat;
    logic end_data;
    logic end_drop;

    logic st_crc;
    logic st_len;
    logic st_aln;
    logic st_ok;

    function automatic logic [31:0] crc_byte(
        input logic [31:0] c,
        input logic [7:0]  d
    );
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ POLY) : (r >> 1);
        end
        return r;
    endfunction

    always_ff @(posedge Clk or negedge mr_main_reset) begin
        if (!mr_main_reset) begin
            state <= WAIT_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            WAIT_IDLE: begin
                if (!RX_DV) state_nxt = IDLE;
            end
            IDLE: begin
                if (RX_DV) begin
                    if (RXD == PRE)      state_nxt = PREAMBLE;
                    else if (RXD == SFD) state_nxt = DATA;
                    else                 state_nxt = DROP;
                end
            end
            PREAMBLE: begin
                if (!RX_DV)          state_nxt = IDLE;
                else if (RXD == SFD) state_nxt = DATA;
                else if (RXD != PRE) state_nxt = DROP;
            end
            DATA: begin
                if (!RX_DV) state_nxt = IDLE;
            end
            DROP: begin
                if (!RX_DV) state_nxt = IDLE;
            end
            default: state_nxt = WAIT_IDLE;
        endcase
    end

    always_comb begin
        start_data = 1'b0;
        data_beat  = 1'b0;
        end_data   = 1'b0;
        end_drop   = 1'b0;
        unique case (state)
            IDLE:     start_data = RX_DV && (RXD == SFD);
            PREAMBLE: start_data = RX_DV && (RXD == SFD);
            DATA: begin
                data_beat = RX_DV;
                end_data  = !RX_DV;
            end
            DROP:     end_drop = !RX_DV;
            default: ;
        endcase
    end

    always_comb begin
        st_crc = end_data && (crc != RESIDUE);
        st_len = end_data && ((len_cnt < MIN_L) || (len_cnt > MAX_L));
        st_aln = end_drop;
        st_ok  = !(st_crc || st_len || st_aln);
    end

    always_ff @(posedge Clk or negedge mr_main_reset) begin
        if (!mr_main_reset) begin
            crc         <= 32'hFFFFFFFF;
            len_cnt     <= '0;
            dly         <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            rx_sof      <= 1'b0;
            frame_done  <= 1'b0;
            frame_ok    <= 1'b0;
            crc_err     <= 1'b0;
            len_err     <= 1'b0;
            align_err   <= 1'b0;
            frame_len   <= '0;
            rx_good_cnt <= '0;
            rx_bad_cnt  <= '0;
        end else begin
            rx_valid   <= 1'b0;
            rx_sof     <= 1'b0;
            frame_done <= 1'b0;

            if (start_data) begin
                crc     <= 32'hFFFFFFFF;
                len_cnt <= '0;
            end

            if (data_beat) begin
                crc <= crc_byte(crc, RXD);
                if (len_cnt != LEN_SAT) len_cnt <= len_cnt + 11'd1;
                dly <= {dly[2:0], RXD};
                // once four bytes are buffered, the oldest is payload
                if (len_cnt >= 11'd4) begin
                    rx_valid <= 1'b1;
                    rx_data  <= dly[3];
                    rx_sof   <= (len_cnt == 11'd4);
                end
            end

            if (end_data || end_drop) begin
                frame_done <= 1'b1;
                frame_ok   <= st_ok;
                crc_err    <= st_crc;
                len_err    <= st_len;
                align_err  <= st_aln;
                frame_len  <= end_data ? len_cnt : 11'd0;
                if (st_ok) begin
                    if (rx_good_cnt != CNT_SAT)
                        rx_good_cnt <= rx_good_cnt + 16'd1;
                end else begin
                    if (rx_bad_cnt != CNT_SAT)
                        rx_bad_cnt <= rx_bad_cnt + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_gmii_rx_frame.sv
// tb_gmii_rx_frame: randomized and directed bench for gmii_rx_frame
// with a queue-based frame model (table-driven CRC, FCS compare).
module tb_gmii_rx_frame;

    localparam int MIN_LEN = 64;
    localparam int MAX_LEN = 1518;

    logic        Clk = 1'b0;
    logic        mr_main_reset = 1'b0;
    logic        RX_DV = 1'b0;
    logic [7:0]  RXD = 8'h00;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_sof;
    logic        frame_done;
    logic        frame_ok;
    logic        crc_err;
    logic        len_err;
    logic        align_err;
    logic [10:0] frame_len;
    logic [15:0] rx_good_cnt;
    logic [15:0] rx_bad_cnt;

    gmii_rx_frame #(
        .MIN_LEN(MIN_LEN),
        .MAX_LEN(MAX_LEN)
    ) dut (
        .Clk(Clk),
        .mr_main_reset(mr_main_reset),
        .RX_DV(RX_DV),
        .RXD(RXD),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_sof(rx_sof),
        .frame_done(frame_done),
        .frame_ok(frame_ok),
        .crc_err(crc_err),
        .len_err(len_err),
        .align_err(align_err),
        .frame_len(frame_len),
        .rx_good_cnt(rx_good_cnt),
        .rx_bad_cnt(rx_bad_cnt)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic        ok;
        logic        crc_e;
        logic        len_e;
        logic        aln_e;
        logic [10:0] flen;
        logic [15:0] good;
        logic [15:0] bad;
    } st_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          m_good = 0;
    int          m_bad = 0;
    logic [31:0] crc_tab [256];
    logic [7:0]  stim [$];
    logic [7:0]  got_pay [$];
    logic [7:0]  exp_pay [$];
    logic        got_sof [$];
    logic        exp_sof [$];
    st_t         got_st [$];
    st_t         exp_st [$];

    always @(posedge Clk) begin
        #1;
        if (rx_valid) begin
            got_pay.push_back(rx_data);
            got_sof.push_back(rx_sof);
        end
        if (frame_done) begin
            got_st.push_back({frame_ok, crc_err, len_err, align_err,
                              frame_len, rx_good_cnt, rx_bad_cnt});
        end
    end

    function automatic logic [31:0] crc_step(input logic [31:0] c,
                                             input logic [7:0] b);
        return crc_tab[c[7:0] ^ b] ^ (c >> 8);
    endfunction

    task automatic clear_q();
        got_pay.delete();
        got_sof.delete();
        got_st.delete();
        exp_pay.delete();
        exp_sof.delete();
        exp_st.delete();
    endtask

    // base < 0: random payload, else payload byte k = base + k
    task automatic build(input int npre, input bit bad_pre,
                         input int plen, input int base, input bit flip);
        logic [31:0] c;
        int          first;
        int          idx;
        stim.delete();
        repeat (npre) stim.push_back(8'h55);
        if (bad_pre) stim.push_back(8'hAA);
        stim.push_back(8'hD5);
        first = stim.size();
        c = 32'hFFFFFFFF;
        for (int k = 0; k < plen; k++) begin
            logic [7:0] b;
            b = (base < 0) ? 8'($urandom) : 8'(base + k);
            stim.push_back(b);
            c = crc_step(c, b);
        end
        c = ~c;
        for (int k = 0; k < 4; k++) stim.push_back(c[8*k +: 8]);
        if (flip) begin
            idx = $urandom_range(first, stim.size() - 1);
            stim[idx] = stim[idx] ^ (8'h01 << $urandom_range(0, 7));
        end
    endtask

    // Frame model: skip 0x55s; an SFD starts the frame, anything else
    // drops it. FCS is checked by recomputing CRC-32 over the payload.
    task automatic model();
        int          i;
        int          n;
        logic [7:0]  d [$];
        logic [31:0] c;
        logic [31:0] fcs;
        st_t         s;
        s = '0;
        i = 0;
        while (i < stim.size() && stim[i] == 8'h55) i++;
        if (i < stim.size() && stim[i] == 8'hD5) begin
            for (int k = i + 1; k < stim.size(); k++) d.push_back(stim[k]);
            n = d.size();
            c = 32'hFFFFFFFF;
            for (int k = 0; k < n - 4; k++) c = crc_step(c, d[k]);
            c = ~c;
            fcs = {d[n-1], d[n-2], d[n-3], d[n-4]};
            s.crc_e = (c != fcs);
            s.len_e = (n < MIN_LEN) || (n > MAX_LEN);
            s.flen  = (n > 2047) ? 11'd2047 : 11'(n);
            for (int k = 0; k < n - 4; k++) begin
                exp_pay.push_back(d[k]);
                exp_sof.push_back(k == 0);
            end
        end else begin
            s.aln_e = 1'b1;
        end
        s.ok = !(s.crc_e || s.len_e || s.aln_e);
        if (s.ok) begin
            if (m_good < 65535) m_good++;
        end else begin
            if (m_bad < 65535) m_bad++;
        end
        s.good = 16'(m_good);
        s.bad  = 16'(m_bad);
        exp_st.push_back(s);
    endtask

    task automatic drive(input logic dv, input logic [7:0] b);
        @(negedge Clk);
        RX_DV = dv;
        RXD   = b;
    endtask

    task automatic send(input int idle);
        foreach (stim[k]) drive(1'b1, stim[k]);
        repeat (idle) drive(1'b0, 8'h00);
    endtask

    task automatic test_reset();
        mr_main_reset = 1'b0;
        RX_DV = 1'b1;
        RXD = 8'h55;
        repeat (3) @(negedge Clk);
        n_cmp++;
        if ({rx_data, rx_valid, rx_sof, frame_done, frame_ok, crc_err,
             len_err, align_err, frame_len} !== '0) begin
            n_bad++;
            $display("FAIL reset_status: got %h want 0",
                     {rx_data, rx_valid, rx_sof, frame_done, frame_ok,
                      crc_err, len_err, align_err, frame_len});
        end
        n_cmp++;
        if ({rx_good_cnt, rx_bad_cnt} !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_cnt: got %h want 0",
                     {rx_good_cnt, rx_bad_cnt});
        end
        mr_main_reset = 1'b1;
        repeat (3) drive(1'b0, 8'h00);
    endtask

    task automatic test_good_frame();
        clear_q();
        build(7, 1'b0, 60, 0, 1'b0);
        model();
        send(4);
        n_cmp++;
        if (got_pay.size() !== exp_pay.size()) begin
            n_bad++;
            $display("FAIL good_beats: got %0d want %0d",
                     got_pay.size(), exp_pay.size());
        end
        for (int k = 0; k < got_pay.size() && k < exp_pay.size(); k++) begin
            n_cmp++;
            if ({got_sof[k], got_pay[k]} !== {exp_sof[k], exp_pay[k]}) begin
                n_bad++;
                $display("FAIL good_pay[%0d]: got %h want %h", k,
                         {got_sof[k], got_pay[k]}, {exp_sof[k], exp_pay[k]});
            end
        end
        n_cmp++;
        if (got_st.size() !== 1) begin
            n_bad++;
            $display("FAIL good_done: got %0d strobes want 1", got_st.size());
        end
        if (got_st.size() > 0) begin
            n_cmp++;
            if (got_st[0] !== exp_st[0]) begin
                n_bad++;
                $display("FAIL good_status: got %h want %h",
                         got_st[0], exp_st[0]);
            end
            n_cmp++;
            if ({got_st[0].ok, got_st[0].flen, got_st[0].good}
                !== {1'b1, 11'd64, 16'd1}) begin
                n_bad++;
                $display("FAIL good_fields: ok %b len %0d good %0d",
                         got_st[0].ok, got_st[0].flen, got_st[0].good);
            end
        end
    endtask

    task automatic test_crc_error();
        clear_q();
        build(7, 1'b0, 60, 0, 1'b0);
        stim[8 + 10] = stim[8 + 10] ^ 8'h04;
        model();
        send(4);
        n_cmp++;
        if (got_pay.size() !== exp_pay.size()) begin
            n_bad++;
            $display("FAIL crc_beats: got %0d want %0d",
                     got_pay.size(), exp_pay.size());
        end
        for (int k = 0; k < got_pay.size() && k < exp_pay.size(); k++) begin
            n_cmp++;
            if ({got_sof[k], got_pay[k]} !== {exp_sof[k], exp_pay[k]}) begin
                n_bad++;
                $display("FAIL crc_pay[%0d]: got %h want %h", k,
                         {got_sof[k], got_pay[k]}, {exp_sof[k], exp_pay[k]});
            end
        end
        n_cmp++;
        if (got_st.size() !== 1) begin
            n_bad++;
            $display("FAIL crc_done: got %0d strobes want 1", got_st.size());
        end
        if (got_st.size() > 0) begin
            n_cmp++;
            if ({got_st[0].crc_e, got_st[0].ok, got_st[0].flen,
                 got_st[0].bad} !== {1'b1, 1'b0, 11'd64, 16'd1}) begin
                n_bad++;
                $display("FAIL crc_status: got %h want crc_err 1 len 64 bad 1",
                         got_st[0]);
            end
            n_cmp++;
            if (got_st[0] !== exp_st[0]) begin
                n_bad++;
                $display("FAIL crc_model: got %h want %h",
                         got_st[0], exp_st[0]);
            end
        end
    endtask

    task automatic test_check_value();
        clear_q();
        stim.delete();
        stim.push_back(8'h55);
        stim.push_back(8'hD5);
        for (int k = 0; k < 9; k++) stim.push_back(8'(8'h31 + k));
        stim.push_back(8'h26);
        stim.push_back(8'h39);
        stim.push_back(8'hF4);
        stim.push_back(8'hCB);
        model();
        send(4);
        n_cmp++;
        if (got_pay.size() !== 9) begin
            n_bad++;
            $display("FAIL chk_beats: got %0d want 9", got_pay.size());
        end
        for (int k = 0; k < got_pay.size() && k < exp_pay.size(); k++) begin
            n_cmp++;
            if ({got_sof[k], got_pay[k]} !== {exp_sof[k], exp_pay[k]}) begin
                n_bad++;
                $display("FAIL chk_pay[%0d]: got %h want %h", k,
                         {got_sof[k], got_pay[k]}, {exp_sof[k], exp_pay[k]});
            end
        end
        n_cmp++;
        if (got_st.size() !== 1) begin
            n_bad++;
            $display("FAIL chk_done: got %0d strobes want 1", got_st.size());
        end
        if (got_st.size() > 0) begin
            n_cmp++;
            if ({got_st[0].crc_e, got_st[0].len_e, got_st[0].flen}
                !== {1'b0, 1'b1, 11'd13}) begin
                n_bad++;
                $display("FAIL chk_status: crc %b len_err %b len %0d",
                         got_st[0].crc_e, got_st[0].len_e, got_st[0].flen);
            end
            n_cmp++;
            if (got_st[0] !== exp_st[0]) begin
                n_bad++;
                $display("FAIL chk_model: got %h want %h",
                         got_st[0], exp_st[0]);
            end
        end
    endtask

    task automatic test_bad_preamble();
        clear_q();
        build(2, 1'b1, 16, -1, 1'b0);
        model();
        send(4);
        n_cmp++;
        if (got_pay.size() !== 0) begin
            n_bad++;
            $display("FAIL aln_beats: got %0d want 0", got_pay.size());
        end
        n_cmp++;
        if (got_st.size() !== 1) begin
            n_bad++;
            $display("FAIL aln_done: got %0d strobes want 1", got_st.size());
        end
        if (got_st.size() > 0) begin
            n_cmp++;
            if ({got_st[0].aln_e, got_st[0].ok, got_st[0].flen}
                !== {1'b1, 1'b0, 11'd0}) begin
                n_bad++;
                $display("FAIL aln_status: align %b ok %b len %0d",
                         got_st[0].aln_e, got_st[0].ok, got_st[0].flen);
            end
            n_cmp++;
            if (got_st[0].bad !== exp_st[0].bad) begin
                n_bad++;
                $display("FAIL aln_cnt: got %0d want %0d",
                         got_st[0].bad, exp_st[0].bad);
            end
        end
    endtask

    task automatic test_back_to_back();
        clear_q();
        build(7, 1'b0, 1596, -1, 1'b0);
        model();
        send(1);
        build(7, 1'b0, 60, -1, 1'b0);
        model();
        send(4);
        n_cmp++;
        if (got_pay.size() !== exp_pay.size()) begin
            n_bad++;
            $display("FAIL b2b_beats: got %0d want %0d",
                     got_pay.size(), exp_pay.size());
        end
        for (int k = 0; k < got_pay.size() && k < exp_pay.size(); k++) begin
            n_cmp++;
            if ({got_sof[k], got_pay[k]} !== {exp_sof[k], exp_pay[k]}) begin
                n_bad++;
                $display("FAIL b2b_pay[%0d]: got %h want %h", k,
                         {got_sof[k], got_pay[k]}, {exp_sof[k], exp_pay[k]});
            end
        end
        n_cmp++;
        if (got_st.size() !== 2) begin
            n_bad++;
            $display("FAIL b2b_done: got %0d strobes want 2", got_st.size());
        end
        for (int k = 0; k < got_st.size() && k < exp_st.size(); k++) begin
            n_cmp++;
            if (got_st[k] !== exp_st[k]) begin
                n_bad++;
                $display("FAIL b2b_status[%0d]: got %h want %h", k,
                         got_st[k], exp_st[k]);
            end
        end
        if (got_st.size() > 1) begin
            n_cmp++;
            if ({got_st[0].len_e, got_st[0].flen, got_st[1].ok,
                 got_st[1].flen} !== {1'b1, 11'd1600, 1'b1, 11'd64}) begin
                n_bad++;
                $display("FAIL b2b_fields: len_err %b len %0d ok %b len %0d",
                         got_st[0].len_e, got_st[0].flen,
                         got_st[1].ok, got_st[1].flen);
            end
        end
    endtask

    task automatic test_len_boundary();
        int lens [4] = '{59, 60, 1514, 1515};
        clear_q();
        for (int f = 0; f < 4; f++) begin
            build($urandom_range(0, 7), 1'b0, lens[f], -1, 1'b0);
            model();
            send(2);
        end
        repeat (2) drive(1'b0, 8'h00);
        n_cmp++;
        if (got_pay.size() !== exp_pay.size()) begin
            n_bad++;
            $display("FAIL bnd_beats: got %0d want %0d",
                     got_pay.size(), exp_pay.size());
        end
        n_cmp++;
        if (got_st.size() !== 4) begin
            n_bad++;
            $display("FAIL bnd_done: got %0d strobes want 4", got_st.size());
        end
        for (int k = 0; k < got_st.size() && k < exp_st.size(); k++) begin
            n_cmp++;
            if (got_st[k] !== exp_st[k]) begin
                n_bad++;
                $display("FAIL bnd_status[%0d]: got %h want %h", k,
                         got_st[k], exp_st[k]);
            end
        end
    endtask

    task automatic test_random();
        clear_q();
        for (int f = 0; f < 10; f++) begin
            build($urandom_range(0, 7), ($urandom_range(0, 9) == 0),
                  $urandom_range(1, 96), -1, ($urandom_range(0, 3) == 0));
            model();
            send($urandom_range(1, 3));
        end
        repeat (3) drive(1'b0, 8'h00);
        n_cmp++;
        if (got_pay.size() !== exp_pay.size()) begin
            n_bad++;
            $display("FAIL rnd_beats: got %0d want %0d",
                     got_pay.size(), exp_pay.size());
        end
        for (int k = 0; k < got_pay.size() && k < exp_pay.size(); k++) begin
            n_cmp++;
            if ({got_sof[k], got_pay[k]} !== {exp_sof[k], exp_pay[k]}) begin
                n_bad++;
                $display("FAIL rnd_pay[%0d]: got %h want %h", k,
                         {got_sof[k], got_pay[k]}, {exp_sof[k], exp_pay[k]});
            end
        end
        n_cmp++;
        if (got_st.size() !== exp_st.size()) begin
            n_bad++;
            $display("FAIL rnd_done: got %0d strobes want %0d",
                     got_st.size(), exp_st.size());
        end
        for (int k = 0; k < got_st.size() && k < exp_st.size(); k++) begin
            n_cmp++;
            if (got_st[k] !== exp_st[k]) begin
                n_bad++;
                $display("FAIL rnd_status[%0d]: got %h want %h", k,
                         got_st[k], exp_st[k]);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        clear_q();
        build(7, 1'b0, 60, 0, 1'b0);
        for (int k = 0; k < 38; k++) drive(1'b1, stim[k]);
        @(negedge Clk);
        RXD = stim[38];
        mr_main_reset = 1'b0;
        #1;
        n_cmp++;
        if ({rx_data, rx_valid, rx_sof, frame_done, frame_ok, crc_err,
             len_err, align_err, frame_len, rx_good_cnt, rx_bad_cnt}
            !== '0) begin
            n_bad++;
            $display("FAIL midrst_clear: got %h want 0",
                     {rx_data, rx_valid, rx_sof, frame_done, frame_ok,
                      crc_err, len_err, align_err, frame_len,
                      rx_good_cnt, rx_bad_cnt});
        end
        got_pay.delete();
        got_sof.delete();
        got_st.delete();
        @(negedge Clk);
        mr_main_reset = 1'b1;
        RXD = stim[39];
        for (int k = 40; k < stim.size(); k++) drive(1'b1, stim[k]);
        repeat (4) drive(1'b0, 8'h00);
        n_cmp++;
        if (got_pay.size() !== 0 || got_st.size() !== 0) begin
            n_bad++;
            $display("FAIL midrst_quiet: beats %0d strobes %0d want 0 0",
                     got_pay.size(), got_st.size());
        end
        m_good = 0;
        m_bad = 0;
        clear_q();
        build(7, 1'b0, 60, -1, 1'b0);
        model();
        send(4);
        n_cmp++;
        if (got_pay.size() !== exp_pay.size()) begin
            n_bad++;
            $display("FAIL midrst_beats: got %0d want %0d",
                     got_pay.size(), exp_pay.size());
        end
        for (int k = 0; k < got_pay.size() && k < exp_pay.size(); k++) begin
            n_cmp++;
            if ({got_sof[k], got_pay[k]} !== {exp_sof[k], exp_pay[k]}) begin
                n_bad++;
                $display("FAIL midrst_pay[%0d]: got %h want %h", k,
                         {got_sof[k], got_pay[k]}, {exp_sof[k], exp_pay[k]});
            end
        end
        n_cmp++;
        if (got_st.size() !== 1) begin
            n_bad++;
            $display("FAIL midrst_done: got %0d strobes want 1",
                     got_st.size());
        end
        if (got_st.size() > 0) begin
            n_cmp++;
            if ({got_st[0].ok, got_st[0].good, got_st[0].bad}
                !== {1'b1, 16'd1, 16'd0}) begin
                n_bad++;
                $display("FAIL midrst_status: ok %b good %0d bad %0d",
                         got_st[0].ok, got_st[0].good, got_st[0].bad);
            end
        end
    endtask

    initial begin
        for (int n = 0; n < 256; n++) begin
            logic [31:0] c;
            c = 32'(n);
            for (int b = 0; b < 8; b++) begin
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            end
            crc_tab[n] = c;
        end
        test_reset();
        test_good_frame();
        test_crc_error();
        test_check_value();
        test_bad_preamble();
        test_back_to_back();
        test_len_boundary();
        test_random();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gmii_rx_frame.md
# gmii_rx_frame

Receive-side GMII frame checker that sits directly downstream of the PCS receive path and consumes its `RX_DV`/`RXD` byte stream. It strips preamble and SFD, checks the Ethernet FCS (CRC-32) and frame length, and forwards payload bytes with the 4 FCS bytes removed through a fixed 4-cycle delay line. It reports one status strobe per frame and keeps saturating good and bad frame counters.

## Interface
- `MIN_LEN`, 64, minimum legal frame length in bytes, counted from after the SFD and including the FCS
- `MAX_LEN`, 1518, maximum legal frame length in bytes, same counting rule
- `Clk`  input  1  single clock; all sampling on the rising edge
- `mr_main_reset`  input  1  reset, asynchronous and active-low
- `RX_DV`  input  1  receive data valid from the PCS
- `RXD`  input  8  receive byte from the PCS
- `rx_data`  output  8  payload byte (FCS stripped)
- `rx_valid`  output  1  `rx_data` is valid this cycle
- `rx_sof`  output  1  marks the first payload byte of a frame, coincident with `rx_valid`
- `frame_done`  output  1  one-cycle frame status strobe
- `frame_ok`  output  1  at `frame_done`: no CRC, length or alignment error
- `crc_err`  output  1  at `frame_done`: FCS mismatch
- `len_err`  output  1  at `frame_done`: `frame_len` < `MIN_LEN` or > `MAX_LEN`
- `align_err`  output  1  at `frame_done`: bad preamble/SFD
- `frame_len`  output  11  at `frame_done`: byte count after the SFD, including the FCS; saturates at 2047
- `rx_good_cnt`  output  16  count of frames with `frame_ok`; saturates at 0xFFFF
- `rx_bad_cnt`  output  16  count of frames without `frame_ok`; saturates at 0xFFFF

## Operation
- States:
  - `WAIT_IDLE` (reset state): stay until `RX_DV`=0 is sampled, then go to `IDLE`.
  - `IDLE`, when `RX_DV`=1:
    - `RXD`=0x55 → `PREAMBLE`
    - `RXD`=0xD5 → `DATA`; a missing preamble is tolerated
    - any other byte → `DROP`
  - `PREAMBLE`:
    - 0x55 → stay
    - 0xD5 → `DATA`
    - any other byte with `RX_DV`=1 → `DROP`
    - `RX_DV`=0 → `IDLE` silently, with no `frame_done` and no count
  - `DATA`:
    - each byte with `RX_DV`=1 updates the CRC, increments the length count and shifts into a 4-byte delay line.
    - `RX_DV`=0 → `IDLE` and issue the status strobe.
  - `DROP`: ignore bytes. `RX_DV`=0 → `IDLE` and issue the status strobe with `align_err`=1, `frame_ok`=0, `frame_len`=0.
- CRC: reflected CRC-32, polynomial 0xEDB88320, initialised to 0xFFFFFFFF on entry to `DATA`, processed LSB first over all bytes including the FCS. The frame passes when the register equals the residue 0xDEBB20E3 at end of frame. `crc_err` = !pass.
- Payload forwarding:
  - A byte is emitted once 4 newer bytes of the same frame have been received; the delay line then holds exactly the FCS at end of frame.
  - Frames of 4 bytes or fewer emit no payload.
  - Payload is forwarded regardless of errors. The consumer qualifies each frame with `frame_ok`.
- `frame_ok` = !`crc_err` & !`len_err` & !`align_err`.
- Counters update on the same edge that raises `frame_done`, so new values are visible together with the strobe. Each counter holds at 0xFFFF once saturated.
- `frame_len` keeps counting past `MAX_LEN` (which sets `len_err`) and holds at 2047 once saturated.

## Timing
- Reset values: all outputs 0, state `WAIT_IDLE`, delay line empty, CRC register 0xFFFFFFFF.
- Reset asserted mid-frame: everything clears at once, with no `frame_done`. After release the block ignores the rest of that frame until `RX_DV` drops.
- All outputs are registered.
- Payload latency: payload byte k (k=0 is the first byte after the SFD) appears with `rx_valid`=1 in the cycle after the edge at which byte k+4 is sampled.
- `rx_valid` is contiguous for the whole payload of a frame.
- `frame_done` is high for exactly one cycle: the cycle after the edge at which `RX_DV`=0 is first sampled in `DATA` or `DROP`. The status outputs are valid in that cycle and hold until the next `frame_done`.
- Back-to-back frames: `RX_DV` high again on the edge right after the end-of-frame edge is accepted from `IDLE`. That frame's `frame_done` may overlap the next frame's preamble cycles.

## Test plan
- 7×0x55, 0xD5, 60 bytes 0x00..0x3B, then a correct 4-byte FCS from the bench model → 60 `rx_valid` beats 0x00..0x3B with `rx_sof` on the 0x00 beat; `frame_done` with `frame_ok`=1, `frame_len`=64; `rx_good_cnt`=1.
- Same frame with one bit of data byte 10 flipped → `crc_err`=1, `frame_ok`=0, `frame_len`=64; `rx_bad_cnt`=1.
- 0x55, 0xD5, bytes 0x31..0x39 ("123456789"), then 0x26 0x39 0xF4 0xCB → 9 payload beats 0x31..0x39; `crc_err`=0, `len_err`=1, `frame_len`=13.
- 0x55, 0x55, 0xAA, 0xD5, 20 bytes → no `rx_valid`; `frame_done` with `align_err`=1, `frame_len`=0.
- 1600-byte frame followed, after 1 idle cycle, by a valid 64-byte frame → first frame: `len_err`=1, `frame_len`=1600. Second frame: `frame_ok`=1, `frame_len`=64; no payload bytes lost.
- Reset asserted for 1 cycle at data byte 30 with `RX_DV` held high → all outputs 0 and no `frame_done` for that frame; the next valid frame passes with `rx_good_cnt`=1.
